spm_serial_mult: RTL and testbench

Signed serial-parallel multiplier built around the carry-save cell chain (per-bit sc/carry registers feeding the half-adder sum stages).
- Multiplicand x is held in parallel; multiplier y is shifted in LSB first, sign-extended.
- Product comes out serially, LSB first, over 2*SIZE cycles.
- A start/busy/done control FSM wraps the array so an upstream master can issue back-to-back multiplies.

---
 rtl/spm_serial_mult.sv | 122 ++++++++++++
 tb/tb_spm_serial_mult.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spm_serial_mult.sv
// Signed serial-parallel multiplier: carry-save cell chain with a start/busy/done wrapper.
// Optional macro SPM_PARALLEL_PRODUCT_EN adds a parallel product register (prod/prod_valid).
module spm_serial_mult #(
   parameter int SIZE = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] x,
   input  logic [SIZE-1:0] y,
   output logic            busy,
   output logic            p,
   output logic            p_valid,
   output logic            done
`ifdef SPM_PARALLEL_PRODUCT_EN
   ,
   output logic [2*SIZE-1:0] prod,
   output logic              prod_valid
`endif
);

   localparam int CW = $clog2(2*SIZE);
   localparam logic [CW-1:0] LAST = CW'(2*SIZE-1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_next;
   logic [SIZE-1:0] x_q;
   logic [SIZE-1:0] y_sr;
   logic [SIZE-1:0] sc, sc_next;
   logic [SIZE-1:0] carry, carry_next;
   logic [CW-1:0]   count;
   logic            ybit;
   logic            accept;
   logic            last;
   logic            pp;
   logic            pp_n;

   assign accept = (state == IDLE) && start;
   assign last   = (count == LAST);

   // Product bits are driven straight from the cell-0 sum so the first bit appears
   // in the cycle right after the accepting edge.
   assign busy    = (state == RUN);
   assign p_valid = busy;
   assign p       = busy & sc_next[0];
   assign done    = busy & last;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sc_next    = '0;
      carry_next = '0;
      pp         = 1'b0;
      // y_sr shifts arithmetically, so its top bit stays the captured sign.
      ybit = (count < CW'(SIZE)) ? y_sr[0] : y_sr[SIZE-1];
      for (int i = 0; i < SIZE-1; i++) begin
         pp            = x_q[i] & ybit;
         sc_next[i]    = pp ^ sc[i+1] ^ carry[i];
         carry_next[i] = (pp & sc[i+1]) | (pp & carry[i]) | (sc[i+1] & carry[i]);
      end
      // Two's-complement MSB cell: inverted partial product, +1 seeded into its carry.
      pp_n             = ~(x_q[SIZE-1] & ybit);
      sc_next[SIZE-1]    = pp_n ^ carry[SIZE-1];
      carry_next[SIZE-1] = pp_n & carry[SIZE-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
      if (!rst) begin
         state <= IDLE;
         x_q   <= '0;
         y_sr  <= '0;
         sc    <= '0;
         carry <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            x_q   <= x;
            y_sr  <= y;
            sc    <= '0;
            carry <= {1'b1, {(SIZE-1){1'b0}}};
            count <= '0;
         end else if (state == RUN) begin
            sc    <= sc_next;
            carry <= carry_next;
            y_sr  <= {y_sr[SIZE-1], y_sr[SIZE-1:1]};
            count <= last ? '0 : count + 1'b1;
         end
      end
   end

`ifdef SPM_PARALLEL_PRODUCT_EN
   logic [2*SIZE-1:0] acc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc        <= '0;
         prod       <= '0;
         prod_valid <= 1'b0;
      end else begin
         prod_valid <= done;
         if (accept) begin
            acc <= '0;
         end else if (state == RUN) begin
            acc <= {p, acc[2*SIZE-1:1]};
            if (last) prod <= {p, acc[2*SIZE-1:1]};
         end
      end
   end
`endif

endmodule

// File: tb/tb_spm_serial_mult.sv
// Self-checking bench for spm_serial_mult (SIZE=8): directed steps plus a product scoreboard.
module tb_spm_serial_mult;

   localparam int SIZE = 8;
   localparam int PW   = 2*SIZE;

   logic            clk;
   logic            rst;
   logic            start;
   logic [SIZE-1:0] x;
   logic [SIZE-1:0] y;
   logic            busy;
   logic            p;
   logic            p_valid;
   logic            done;
`ifdef SPM_PARALLEL_PRODUCT_EN
   logic [PW-1:0]   prod;
   logic            prod_valid;
`endif

   int checks = 0;
   int errors = 0;

   logic [PW-1:0] sb[$];
   logic [PW-1:0] mon_acc;
   logic [PW-1:0] last_exp;
   int            mon_cnt = 0;
   logic          prod_pend = 1'b0;

   spm_serial_mult #(.SIZE(SIZE)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x          (x),
      .y          (y),
      .busy       (busy),
      .p          (p),
      .p_valid    (p_valid),
      .done       (done)
`ifdef SPM_PARALLEL_PRODUCT_EN
      ,
      .prod       (prod),
      .prod_valid (prod_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [PW-1:0] model(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
      logic signed [PW-1:0] m;
      m = $signed(a) * $signed(b);
      return m;
   endfunction

   // Monitor: assemble serial bits and compare against the scoreboard on the last bit.
   always @(negedge clk) begin
`ifdef SPM_PARALLEL_PRODUCT_EN
      if (prod_pend && rst) begin
         check("prod_valid_pulse", 64'(prod_valid), 64'(1));
         check("prod_value", 64'(prod), 64'(last_exp));
      end
`endif
      prod_pend = 1'b0;
      if (!rst) begin
         mon_cnt = 0;
         mon_acc = '0;
      end else if (p_valid) begin
         if (mon_cnt < PW) mon_acc[mon_cnt] = p;
         mon_cnt++;
         if (done || mon_cnt >= PW) begin
            check("done_on_last_bit", 64'(done), 64'(1));
            check("bit_count", 64'(mon_cnt), 64'(PW));
            check("scoreboard_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               last_exp = sb.pop_front();
               check("product", 64'(mon_acc), 64'(last_exp));
            end
            mon_cnt   = 0;
            prod_pend = 1'b1;
         end
      end
   end

   task automatic wait_done(input bit scramble);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4*PW; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (scramble) begin
            #1;
            x = SIZE'($urandom);
            y = SIZE'($urandom);
         end
      end
      check("done_within_budget", 64'(seen), 64'(1));
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after the run.
   task automatic run_one(input logic [SIZE-1:0] xv, input logic [SIZE-1:0] yv,
                          input logic [PW-1:0] exp, input bit scramble);
      start = 1'b1;
      x     = xv;
      y     = yv;
      sb.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", 64'(busy), 64'(1));
      check("p_valid_latency", 64'(p_valid), 64'(1));
      wait_done(scramble);
      @(posedge clk); #1;
      check("busy_low_after_done", 64'(busy), 64'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [SIZE-1:0] rx, ry;
      rst   = 1'b0;
      start = 1'b0;
      x     = '0;
      y     = '0;
      #1;
      check("reset_busy", 64'(busy), 64'(0));
      check("reset_p", 64'(p), 64'(0));
      check("reset_p_valid", 64'(p_valid), 64'(0));
      check("reset_done", 64'(done), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_one(8'h03, 8'h05, 16'h000F, 1'b0);
      run_one(8'hFF, 8'h01, 16'hFFFF, 1'b0);
      run_one(8'h80, 8'h80, 16'h4000, 1'b0);
      run_one(8'h7F, 8'h80, 16'hC080, 1'b0);
      run_one(8'h00, 8'hA5, 16'h0000, 1'b0);
      run_one(8'h5A, 8'h00, 16'h0000, 1'b0);

      // Start held high: one idle accept cycle between runs, starts while busy ignored.
      start = 1'b1;
      x     = 8'h02;
      y     = 8'h03;
      sb.push_back(16'h0006);
      for (int r = 0; r < 3; r++) begin
         @(posedge clk); #1;
         check("b2b_busy_run", 64'(busy), 64'(1));
         wait_done(1'b0);
         @(posedge clk); #1;
         check("b2b_idle_gap", 64'(busy), 64'(0));
         if (r < 2) sb.push_back(16'h0006);
         else       start = 1'b0;
      end
      @(posedge clk); #1;
      check("b2b_stays_idle", 64'(busy), 64'(0));

      // Abort at count=5, then a clean rerun of the same operands.
      start = 1'b1;
      x     = 8'h55;
      y     = 8'h33;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_p", 64'(p), 64'(0));
      check("abort_p_valid", 64'(p_valid), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_one(8'h55, 8'h33, 16'h10EF, 1'b0);

      // Operands scrambled during RUN must not affect the result.
      for (int i = 0; i < 4; i++) begin
         rx = SIZE'($urandom);
         ry = SIZE'($urandom);
         run_one(rx, ry, model(rx, ry), 1'b1);
      end

      run_one(8'h9C, 8'h07, 16'hFD44, 1'b0);
`ifdef SPM_PARALLEL_PRODUCT_EN
      repeat (3) @(posedge clk);
      #1;
      check("prod_hold", 64'(prod), 64'(16'hFD44));
      check("prod_valid_single", 64'(prod_valid), 64'(0));
`endif

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
